// File: rtl/mem_pkg.sv
// Shared types and constants for the RV32I memory-access stage.
// Holds the opcode/funct3 encodings, FSM states and the MEM/WB record.
package mem_pkg;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_DONE = 2'b10
  } mem_state_e;

  typedef struct packed {
    logic [31:0] alu;
    logic [31:0] mem;
    logic [31:0] pc4;
    logic [31:0] inst;
    logic [1:0]  wbsel;
    logic        regwen;
    logic [4:0]  rsw;
  } wb_t;

  localparam wb_t WB_BUBBLE = '{alu: 32'h0, mem: 32'h0, pc4: 32'h0, inst: 32'h0,
                                wbsel: 2'b00, regwen: 1'b0, rsw: 5'd0};

  // Unknown funct3 encodings behave as word accesses.
  function automatic logic access_misaligned(input logic [2:0] f3, input logic [1:0] a);
    case (f3)
      F3_B, F3_BU: return 1'b0;
      F3_H, F3_HU: return a[0];
      F3_W:        return (a != 2'b00);
      default:     return (a != 2'b00);
    endcase
  endfunction

endpackage

// File: rtl/load_extend.sv
// Selects the addressed byte/halfword lane of a read word and
// sign- or zero-extends it according to funct3.
module load_extend
  import mem_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  output logic [31:0] ext_data
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Lane select then extension.
  always_comb begin
    byte_s = 8'h00;
    case (addr_lo)
      2'b00:   byte_s = rdata[7:0];
      2'b01:   byte_s = rdata[15:8];
      2'b10:   byte_s = rdata[23:16];
      2'b11:   byte_s = rdata[31:24];
      default: byte_s = rdata[7:0];
    endcase
    if (addr_lo[1]) begin
      half_s = rdata[31:16];
    end else begin
      half_s = rdata[15:0];
    end
    case (funct3)
      F3_B:    ext_data = {{24{byte_s[7]}}, byte_s};
      F3_BU:   ext_data = {24'h000000, byte_s};
      F3_H:    ext_data = {{16{half_s[15]}}, half_s};
      F3_HU:   ext_data = {16'h0000, half_s};
      F3_W:    ext_data = rdata;
      default: ext_data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// MEM stage: issues handshaked data-memory transactions, stalls upstream
// while one is outstanding, and owns the MEM/WB pipeline register.
module mem_stage
  import mem_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [31:0] alu_mem_i,
  input  logic [31:0] rs2_mem_i,
  input  logic [31:0] pc4_mem_i,
  input  logic        MemRW_mem_i,
  input  logic [1:0]  WBSel_mem_i,
  input  logic        RegWEn_mem_i,
  input  logic [4:0]  rsW_mem_i,
  input  logic [31:0] inst_mem_i,
  input  logic        enable_i,
  input  logic        reset_i,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [31:0] dmem_addr_o,
  output logic [31:0] dmem_wdata_o,
  output logic [3:0]  dmem_be_o,
  input  logic [31:0] dmem_rdata_i,
  input  logic        dmem_ack_i,
  output logic        stall_o,
  output logic        misalign_o,
  output logic [31:0] alu_wb_o,
  output logic [31:0] mem_wb_o,
  output logic [31:0] pc4_wb_o,
  output logic [31:0] inst_wb_o,
  output logic [1:0]  WBSel_wb_o,
  output logic        RegWEn_wb_o,
  output logic [4:0]  rsW_wb_o
);

  mem_state_e  state_r, state_nxt_s;
  logic        is_load_s, memop_s, misalign_s, issue_s, stall_s;
  logic [2:0]  funct3_s;
  logic [1:0]  addr_lo_s;
  logic [31:0] wdata_s, load_src_s, ext_s, rdata_r;
  logic [3:0]  be_s;
  logic        req_r, we_r;
  logic [31:0] addr_r, wdata_r;
  logic [3:0]  be_r;
  wb_t         wb_r, wb_nxt_s;

  assign funct3_s   = inst_mem_i[14:12];
  assign addr_lo_s  = alu_mem_i[1:0];
  assign is_load_s  = (inst_mem_i[6:0] == OP_LOAD);
  assign memop_s    = is_load_s | MemRW_mem_i;
  assign misalign_s = memop_s & access_misaligned(funct3_s, addr_lo_s);
  assign issue_s    = memop_s & ~misalign_s;

  // Store lane replication and byte enables (also used as read enables).
  always_comb begin
    case (funct3_s)
      F3_B, F3_BU: begin
        wdata_s = {4{rs2_mem_i[7:0]}};
        be_s    = 4'b0001 << addr_lo_s;
      end
      F3_H, F3_HU: begin
        wdata_s = {2{rs2_mem_i[15:0]}};
        be_s    = addr_lo_s[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        wdata_s = rs2_mem_i;
        be_s    = 4'b1111;
      end
    endcase
  end

  // Next-state and stall decode.
  always_comb begin
    state_nxt_s = state_r;
    stall_s     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (issue_s) begin
          state_nxt_s = ST_BUSY;
          stall_s     = 1'b1;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (dmem_ack_i) begin
          state_nxt_s = enable_i ? ST_IDLE : ST_DONE;
        end else begin
          state_nxt_s = ST_BUSY;
          stall_s     = 1'b1;
        end
      end
      ST_DONE: begin
        if (enable_i) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_DONE;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Bus outputs are launched from IDLE and held until the ack edge.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      req_r   <= 1'b0;
      we_r    <= 1'b0;
      addr_r  <= 32'h0;
      wdata_r <= 32'h0;
      be_r    <= 4'b0000;
    end else if ((state_r == ST_IDLE) && issue_s) begin
      req_r   <= 1'b1;
      we_r    <= MemRW_mem_i;
      addr_r  <= {alu_mem_i[31:2], 2'b00};
      wdata_r <= wdata_s;
      be_r    <= be_s;
    end else if ((state_r == ST_BUSY) && dmem_ack_i) begin
      req_r   <= 1'b0;
    end
  end

  // Read data captured at ack so it survives a DONE wait.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rdata_r <= 32'h0;
    end else if ((state_r == ST_BUSY) && dmem_ack_i) begin
      rdata_r <= dmem_rdata_i;
    end
  end

  assign load_src_s = (state_r == ST_BUSY) ? dmem_rdata_i : rdata_r;

  load_extend u_load_extend (
    .rdata    (load_src_s),
    .addr_lo  (addr_lo_s),
    .funct3   (funct3_s),
    .ext_data (ext_s)
  );

  // MEM/WB next value: hold, flush/bubble, or load.
  always_comb begin
    wb_nxt_s = wb_r;
    if (!enable_i) begin
      wb_nxt_s = wb_r;
    end else if (reset_i || stall_s) begin
      wb_nxt_s = WB_BUBBLE;
    end else begin
      wb_nxt_s.alu    = alu_mem_i;
      wb_nxt_s.mem    = (is_load_s && !misalign_s) ? ext_s : 32'h0;
      wb_nxt_s.pc4    = pc4_mem_i;
      wb_nxt_s.inst   = inst_mem_i;
      wb_nxt_s.wbsel  = WBSel_mem_i;
      wb_nxt_s.regwen = RegWEn_mem_i & ~misalign_s;
      wb_nxt_s.rsw    = rsW_mem_i;
    end
  end

  // MEM/WB register.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wb_r <= WB_BUBBLE;
    end else begin
      wb_r <= wb_nxt_s;
    end
  end

  assign dmem_req_o   = req_r;
  assign dmem_we_o    = we_r;
  assign dmem_addr_o  = addr_r;
  assign dmem_wdata_o = wdata_r;
  assign dmem_be_o    = be_r;
  assign stall_o      = stall_s;
  assign misalign_o   = misalign_s;
  assign alu_wb_o     = wb_r.alu;
  assign mem_wb_o     = wb_r.mem;
  assign pc4_wb_o     = wb_r.pc4;
  assign inst_wb_o    = wb_r.inst;
  assign WBSel_wb_o   = wb_r.wbsel;
  assign RegWEn_wb_o  = wb_r.regwen;
  assign rsW_wb_o     = wb_r.rsw;

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: stimulus queues expected WB records and
// bus transactions; a bus responder and a WB monitor pop and compare.
module tb_mem_stage;
  import mem_pkg::*;

  logic        clk = 1'b0;
  logic        rst_ni = 1'b0;
  logic [31:0] alu_mem_i = 32'h0, rs2_mem_i = 32'h0, pc4_mem_i = 32'h0, inst_mem_i = 32'h0;
  logic        MemRW_mem_i = 1'b0, RegWEn_mem_i = 1'b0, enable_i = 1'b1, reset_i = 1'b0;
  logic [1:0]  WBSel_mem_i = 2'b00;
  logic [4:0]  rsW_mem_i = 5'd0;
  logic        dmem_req_o, dmem_we_o, stall_o, misalign_o, RegWEn_wb_o;
  logic [31:0] dmem_addr_o, dmem_wdata_o, alu_wb_o, mem_wb_o, pc4_wb_o, inst_wb_o;
  logic [3:0]  dmem_be_o;
  logic [31:0] dmem_rdata_i = 32'h0;
  logic        dmem_ack_i = 1'b0;
  logic [1:0]  WBSel_wb_o;
  logic [4:0]  rsW_wb_o;

  mem_stage dut (
    .clk_i(clk), .rst_ni(rst_ni), .alu_mem_i(alu_mem_i), .rs2_mem_i(rs2_mem_i),
    .pc4_mem_i(pc4_mem_i), .MemRW_mem_i(MemRW_mem_i), .WBSel_mem_i(WBSel_mem_i),
    .RegWEn_mem_i(RegWEn_mem_i), .rsW_mem_i(rsW_mem_i), .inst_mem_i(inst_mem_i),
    .enable_i(enable_i), .reset_i(reset_i), .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o),
    .dmem_addr_o(dmem_addr_o), .dmem_wdata_o(dmem_wdata_o), .dmem_be_o(dmem_be_o),
    .dmem_rdata_i(dmem_rdata_i), .dmem_ack_i(dmem_ack_i), .stall_o(stall_o),
    .misalign_o(misalign_o), .alu_wb_o(alu_wb_o), .mem_wb_o(mem_wb_o), .pc4_wb_o(pc4_wb_o),
    .inst_wb_o(inst_wb_o), .WBSel_wb_o(WBSel_wb_o), .RegWEn_wb_o(RegWEn_wb_o), .rsW_wb_o(rsW_wb_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] alu, mem, pc4, inst;
    logic [1:0]  wbsel;
    logic        regwen;
    logic [4:0]  rsw;
  } exp_wb_t;

  typedef struct {
    logic        we;
    logic [31:0] addr, wdata;
    logic [3:0]  be;
    int          lat;
    logic [31:0] rdata;
  } bus_t;

  exp_wb_t     wb_q[$];
  bus_t        bus_q[$];
  int          n_cmp = 0, n_bad = 0;
  logic [31:0] pc = 32'h100;
  logic [31:0] last_inst = 32'h0;
  logic [31:0] last_mem = 32'h0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [6:0] op, input logic [2:0] f3, input logic [4:0] rd);
    return {12'h000, 5'd2, f3, rd, op};
  endfunction

  // Bus responder: pops the expected transaction on a new request,
  // checks it stays stable, and acks after the queued latency.
  bus_t cur;
  int   r_cnt = 0;
  logic active = 1'b0;
  always @(negedge clk) begin
    if (!dmem_req_o) begin
      dmem_ack_i   = 1'b0;
      dmem_rdata_i = 32'h0;
      active       = 1'b0;
    end else begin
      if (!active) begin
        active = 1'b1;
        if (bus_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_req: request at addr %h, expected none", dmem_addr_o);
          cur = '{we: 1'b0, addr: 32'h0, wdata: 32'h0, be: 4'b0000, lat: 0, rdata: 32'h0};
          cur.addr = dmem_addr_o; cur.we = dmem_we_o; cur.wdata = dmem_wdata_o; cur.be = dmem_be_o;
        end else begin
          cur = bus_q.pop_front();
        end
        r_cnt = cur.lat;
      end
      chk("bus_we", {31'h0, dmem_we_o}, {31'h0, cur.we});
      chk("bus_addr", dmem_addr_o, cur.addr);
      chk("bus_wdata", dmem_wdata_o, cur.wdata);
      chk("bus_be", {28'h0, dmem_be_o}, {28'h0, cur.be});
      if (r_cnt == 0) begin
        dmem_ack_i   = 1'b1;
        dmem_rdata_i = cur.rdata;
      end else begin
        r_cnt--;
        dmem_ack_i   = 1'b0;
        dmem_rdata_i = 32'h0;
      end
    end
  end

  // WB monitor: every non-bubble load of MEM/WB is matched against the queue.
  logic    mon_en;
  exp_wb_t mon_e;
  always @(posedge clk) begin
    mon_en = enable_i & rst_ni;
    #1;
    if (mon_en && inst_wb_o != 32'h0) begin
      if (wb_q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL wb_unexpected: inst %h reached WB, expected nothing", inst_wb_o);
      end else begin
        mon_e = wb_q.pop_front();
        chk("wb_inst", inst_wb_o, mon_e.inst);
        chk("wb_alu", alu_wb_o, mon_e.alu);
        chk("wb_mem", mem_wb_o, mon_e.mem);
        chk("wb_pc4", pc4_wb_o, mon_e.pc4);
        chk("wb_wbsel", {30'h0, WBSel_wb_o}, {30'h0, mon_e.wbsel});
        chk("wb_regwen", {31'h0, RegWEn_wb_o}, {31'h0, mon_e.regwen});
        chk("wb_rsw", {27'h0, rsW_wb_o}, {27'h0, mon_e.rsw});
      end
    end
  end

  task automatic drive_nop();
    @(negedge clk);
    inst_mem_i = 32'h0; alu_mem_i = 32'h0; rs2_mem_i = 32'h0; MemRW_mem_i = 1'b0;
    RegWEn_mem_i = 1'b0; WBSel_mem_i = 2'b00; rsW_mem_i = 5'd0;
    enable_i = 1'b1; reset_i = 1'b0;
  endtask

  task automatic op(input string nm, input logic [31:0] inst, alu, rs2,
                    input logic memrw, regwen, input logic [31:0] exp_mem,
                    input int exp_cyc, input logic exp_mis,
                    input logic bus, input logic [31:0] baddr, bwdata, input logic [3:0] bbe,
                    input int lat, input logic [31:0] rdata, input logic flush, input logic en);
    bus_t    b;
    exp_wb_t w;
    int      cycles;
    logic    mis;
    if (bus) begin
      b.we = memrw; b.addr = baddr; b.wdata = bwdata; b.be = bbe; b.lat = lat; b.rdata = rdata;
      bus_q.push_back(b);
    end
    if (!flush) begin
      w.alu = alu; w.mem = exp_mem; w.pc4 = pc; w.inst = inst; w.wbsel = inst[5:4];
      w.regwen = regwen & ~exp_mis; w.rsw = inst[11:7];
      wb_q.push_back(w);
    end
    @(negedge clk);
    inst_mem_i = inst; alu_mem_i = alu; rs2_mem_i = rs2; pc4_mem_i = pc;
    MemRW_mem_i = memrw; WBSel_mem_i = inst[5:4]; RegWEn_mem_i = regwen;
    rsW_mem_i = inst[11:7]; enable_i = en; reset_i = flush;
    #2;
    mis = misalign_o;
    cycles = 1;
    while (stall_o && cycles < 40) begin
      @(negedge clk);
      #2;
      cycles++;
    end
    chk({nm, "_stall_timeout"}, {31'h0, stall_o}, 32'h0);
    chk({nm, "_cycles"}, cycles, exp_cyc);
    chk({nm, "_misalign"}, {31'h0, mis}, {31'h0, exp_mis});
    if (!en) begin
      @(negedge clk);
      #2;
      chk({nm, "_done_stall"}, {31'h0, stall_o}, 32'h0);
      chk({nm, "_done_req"}, {31'h0, dmem_req_o}, 32'h0);
      chk({nm, "_done_hold_inst"}, inst_wb_o, last_inst);
      chk({nm, "_done_hold_mem"}, mem_wb_o, last_mem);
      enable_i = 1'b1;
    end
    if (!flush) begin
      last_inst = inst;
      last_mem  = exp_mem;
    end
    pc = pc + 32'd4;
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    #2;
    chk("rst_req", {31'h0, dmem_req_o}, 32'h0);
    chk("rst_stall", {31'h0, stall_o}, 32'h0);
    chk("rst_addr", dmem_addr_o, 32'h0);
    chk("rst_be", {28'h0, dmem_be_o}, 32'h0);
    chk("rst_wb_inst", inst_wb_o, 32'h0);
    chk("rst_wb_regwen", {31'h0, RegWEn_wb_o}, 32'h0);
    rst_ni = 1'b1;

    op("add1", mk(7'b0110011, 3'b000, 5'd5), 32'h30, 32'h0, 1'b0, 1'b1, 32'h0, 1, 1'b0,
       1'b0, 32'h0, 32'h0, 4'b0000, 0, 32'h0, 1'b0, 1'b1);
    op("sb", mk(OP_STORE, F3_B, 5'd0), 32'h1003, 32'h000000AB, 1'b1, 1'b0, 32'h0, 2, 1'b0,
       1'b1, 32'h1000, 32'hABABABAB, 4'b1000, 0, 32'h0, 1'b0, 1'b1);
    op("lb", mk(OP_LOAD, F3_B, 5'd6), 32'h2002, 32'h0, 1'b0, 1'b1, 32'hFFFFFF80, 5, 1'b0,
       1'b1, 32'h2000, 32'h0, 4'b0100, 3, 32'h1280FF34, 1'b0, 1'b1);
    op("lbu", mk(OP_LOAD, F3_BU, 5'd6), 32'h2002, 32'h0, 1'b0, 1'b1, 32'h00000080, 2, 1'b0,
       1'b1, 32'h2000, 32'h0, 4'b0100, 0, 32'h1280FF34, 1'b0, 1'b1);
    op("lw_mis", mk(OP_LOAD, F3_W, 5'd7), 32'h2001, 32'h0, 1'b0, 1'b1, 32'h0, 1, 1'b1,
       1'b0, 32'h0, 32'h0, 4'b0000, 0, 32'h0, 1'b0, 1'b1);
    op("add2", mk(7'b0110011, 3'b000, 5'd3), 32'h55, 32'h0, 1'b0, 1'b1, 32'h0, 1, 1'b0,
       1'b0, 32'h0, 32'h0, 4'b0000, 0, 32'h0, 1'b0, 1'b1);
    op("sw", mk(OP_STORE, F3_W, 5'd0), 32'h10, 32'h12345678, 1'b1, 1'b0, 32'h0, 2, 1'b0,
       1'b1, 32'h10, 32'h12345678, 4'b1111, 0, 32'h0, 1'b0, 1'b1);
    op("lh", mk(OP_LOAD, F3_H, 5'd8), 32'h2, 32'h0, 1'b0, 1'b1, 32'hFFFF8001, 2, 1'b0,
       1'b1, 32'h0, 32'h0, 4'b1100, 0, 32'h80010000, 1'b0, 1'b1);
    op("sh", mk(OP_STORE, F3_H, 5'd0), 32'h102, 32'hCAFEBEEF, 1'b1, 1'b0, 32'h0, 3, 1'b0,
       1'b1, 32'h100, 32'hBEEFBEEF, 4'b1100, 1, 32'h0, 1'b0, 1'b1);
    op("lhu", mk(OP_LOAD, F3_HU, 5'd9), 32'h6, 32'h0, 1'b0, 1'b1, 32'h00008001, 2, 1'b0,
       1'b1, 32'h4, 32'h0, 4'b1100, 0, 32'h80011234, 1'b0, 1'b1);
    op("lw_done", mk(OP_LOAD, F3_W, 5'd10), 32'h3000, 32'h0, 1'b0, 1'b1, 32'hDEADBEEF, 3, 1'b0,
       1'b1, 32'h3000, 32'h0, 4'b1111, 1, 32'hDEADBEEF, 1'b0, 1'b0);
    op("sw_flush", mk(OP_STORE, F3_W, 5'd0), 32'h20, 32'h0BADF00D, 1'b1, 1'b0, 32'h0, 2, 1'b0,
       1'b1, 32'h20, 32'h0BADF00D, 4'b1111, 0, 32'h0, 1'b1, 1'b1);
    drive_nop();
    #2;
    chk("flush_wb_inst", inst_wb_o, 32'h0);
    chk("flush_wb_regwen", {31'h0, RegWEn_wb_o}, 32'h0);

    // Reset in the middle of a BUSY wait
    begin
      bus_t b;
      b.we = 1'b0; b.addr = 32'h4000; b.wdata = 32'h0; b.be = 4'b1111; b.lat = 5; b.rdata = 32'h55;
      bus_q.push_back(b);
    end
    @(negedge clk);
    inst_mem_i = mk(OP_LOAD, F3_W, 5'd11); alu_mem_i = 32'h4000; RegWEn_mem_i = 1'b1;
    #2;
    chk("rstbusy_issue_stall", {31'h0, stall_o}, 32'h1);
    @(negedge clk);
    #2;
    chk("rstbusy_req", {31'h0, dmem_req_o}, 32'h1);
    rst_ni = 1'b0;
    inst_mem_i = 32'h0; alu_mem_i = 32'h0; RegWEn_mem_i = 1'b0;
    @(negedge clk);
    #2;
    chk("rstbusy_req_low", {31'h0, dmem_req_o}, 32'h0);
    chk("rstbusy_stall_low", {31'h0, stall_o}, 32'h0);
    chk("rstbusy_wb_inst", inst_wb_o, 32'h0);
    chk("rstbusy_wb_alu", alu_wb_o, 32'h0);
    chk("rstbusy_wb_mem", mem_wb_o, 32'h0);
    chk("rstbusy_wb_pc4", pc4_wb_o, 32'h0);
    chk("rstbusy_wb_rsw", {27'h0, rsW_wb_o}, 32'h0);
    rst_ni = 1'b1;

    op("add3", mk(7'b0110011, 3'b000, 5'd12), 32'h77, 32'h0, 1'b0, 1'b1, 32'h0, 1, 1'b0,
       1'b0, 32'h0, 32'h0, 4'b0000, 0, 32'h0, 1'b0, 1'b1);
    drive_nop();
    repeat (3) @(negedge clk);
    chk("wb_queue_empty", wb_q.size(), 32'h0);
    chk("bus_queue_empty", bus_q.size(), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
